// File: rtl/mips_mc_control.sv
// Multi-cycle MIPS control FSM: sequences each instruction through fetch, decode,
// execute, memory and writeback, driving ALU selects, enables and PC update.
`timescale 1ns/1ps
module mips_mc_control (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero_signal,
    input  logic       mem_ready,
    output logic       ir_write,
    output logic       pc_write,
    output logic [1:0] pc_src,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       reg_write,
    output logic [1:0] reg_dst,
    output logic [1:0] mem_to_reg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic       ext_sel,
    output logic [3:0] alu_control,
    output logic       instr_done,
    output logic       illegal,
    output logic [3:0] state
);

    localparam logic [3:0] S_FETCH   = 4'd0;
    localparam logic [3:0] S_DECODE  = 4'd1;
    localparam logic [3:0] S_MEMADR  = 4'd2;
    localparam logic [3:0] S_MEMRD   = 4'd3;
    localparam logic [3:0] S_MEMWB   = 4'd4;
    localparam logic [3:0] S_MEMWR   = 4'd5;
    localparam logic [3:0] S_EXEC_R  = 4'd6;
    localparam logic [3:0] S_RWB     = 4'd7;
    localparam logic [3:0] S_EXEC_I  = 4'd8;
    localparam logic [3:0] S_IWB     = 4'd9;
    localparam logic [3:0] S_BRANCH  = 4'd10;
    localparam logic [3:0] S_JAL     = 4'd11;
    localparam logic [3:0] S_JR      = 4'd12;
    localparam logic [3:0] S_ILLEGAL = 4'd13;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_NOR = 6'b100111;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_SLL = 6'b000000;
    localparam logic [5:0] FN_JR  = 6'b001000;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_ANDI = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_ADDI = 4'b0011;
    localparam logic [3:0] ALU_SLL  = 4'b0100;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_LW   = 4'b1000;
    localparam logic [3:0] ALU_SW   = 4'b1001;
    localparam logic [3:0] ALU_BEQ  = 4'b1010;
    localparam logic [3:0] ALU_JAL  = 4'b1011;
    localparam logic [3:0] ALU_NOR  = 4'b1100;
    localparam logic [3:0] ALU_JR   = 4'b1111;

    logic [3:0] next_state;
    // Instruction flavour remembered from DECODE so later states need not re-read the IR.
    logic       is_store;
    logic       is_andi;

    function automatic logic funct_ok(input logic [5:0] f);
        return (f == FN_ADD) || (f == FN_AND) || (f == FN_NOR) ||
               (f == FN_SLT) || (f == FN_SLL);
    endfunction

    function automatic logic [3:0] r_code(input logic [5:0] f);
        logic [3:0] c;
        case (f)
            FN_AND:  c = ALU_AND;
            FN_NOR:  c = ALU_NOR;
            FN_SLT:  c = ALU_SLT;
            FN_SLL:  c = ALU_SLL;
            default: c = ALU_ADD;
        endcase
        return c;
    endfunction

    // State register and decoded instruction flavour
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_FETCH;
            is_store <= 1'b0;
            is_andi  <= 1'b0;
        end else begin
            state <= next_state;
            if (state == S_DECODE) begin
                is_store <= (opcode == OP_SW);
                is_andi  <= (opcode == OP_ANDI);
            end
        end
    end

    // Next state and control outputs
    always_comb begin
        next_state  = state;
        ir_write    = 1'b0;
        pc_write    = 1'b0;
        pc_src      = 2'b00;
        i_or_d      = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        reg_write   = 1'b0;
        reg_dst     = 2'b00;
        mem_to_reg  = 2'b00;
        alu_src_a   = 1'b0;
        alu_src_b   = 2'b00;
        ext_sel     = 1'b0;
        alu_control = ALU_ADD;
        instr_done  = 1'b0;
        illegal     = 1'b0;

        case (state)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
                if (mem_ready) next_state = S_DECODE;
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                case (opcode)
                    OP_LW, OP_SW:     next_state = S_MEMADR;
                    OP_ADDI, OP_ANDI: next_state = S_EXEC_I;
                    OP_BEQ:           next_state = S_BRANCH;
                    OP_JAL:           next_state = S_JAL;
                    OP_RTYPE: begin
                        if (funct == FN_JR)     next_state = S_JR;
                        else if (funct_ok(funct)) next_state = S_EXEC_R;
                        else                    next_state = S_ILLEGAL;
                    end
                    default:          next_state = S_ILLEGAL;
                endcase
            end
            S_MEMADR: begin
                alu_src_a   = 1'b1;
                alu_src_b   = 2'b10;
                alu_control = is_store ? ALU_SW : ALU_LW;
                next_state  = is_store ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
                if (mem_ready) next_state = S_MEMWB;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 2'b01;
                instr_done = 1'b1;
                next_state = S_FETCH;
            end
            S_MEMWR: begin
                mem_write  = 1'b1;
                i_or_d     = 1'b1;
                instr_done = mem_ready;
                if (mem_ready) next_state = S_FETCH;
            end
            S_EXEC_R: begin
                alu_src_a   = 1'b1;
                alu_control = r_code(funct);
                next_state  = S_RWB;
            end
            S_RWB: begin
                reg_write  = 1'b1;
                reg_dst    = 2'b01;
                instr_done = 1'b1;
                next_state = S_FETCH;
            end
            S_EXEC_I: begin
                alu_src_a   = 1'b1;
                alu_src_b   = 2'b10;
                ext_sel     = is_andi;
                alu_control = is_andi ? ALU_ANDI : ALU_ADDI;
                next_state  = S_IWB;
            end
            S_IWB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
                next_state = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a   = 1'b1;
                alu_control = ALU_BEQ;
                pc_src      = 2'b01;
                pc_write    = zero_signal;
                instr_done  = 1'b1;
                next_state  = S_FETCH;
            end
            S_JAL: begin
                alu_control = ALU_JAL;
                pc_write    = 1'b1;
                pc_src      = 2'b10;
                reg_write   = 1'b1;
                reg_dst     = 2'b10;
                mem_to_reg  = 2'b10;
                instr_done  = 1'b1;
                next_state  = S_FETCH;
            end
            S_JR: begin
                alu_src_a   = 1'b1;
                alu_control = ALU_JR;
                pc_write    = 1'b1;
                pc_src      = 2'b11;
                instr_done  = 1'b1;
                next_state  = S_FETCH;
            end
            S_ILLEGAL: begin
                illegal    = 1'b1;
                next_state = S_FETCH;
            end
            default: next_state = S_FETCH;
        endcase

        // Reset suppresses every side effect, including the Mealy strobes.
        if (rst) begin
            ir_write    = 1'b0;
            pc_write    = 1'b0;
            mem_read    = 1'b0;
            mem_write   = 1'b0;
            reg_write   = 1'b0;
            instr_done  = 1'b0;
            illegal     = 1'b0;
            alu_control = ALU_ADD;
        end
    end

endmodule

// File: doc/mips_mc_control.md
# mips_mc_control

Multi-cycle control FSM for the MIPS datapath. Each instruction is sequenced through fetch, decode, execute, memory and writeback states. In each state the block drives the ALU's 4-bit `alu_control` code, its operand selects, the register-file and memory enables, and the PC update. It sits between the instruction register and the shared ALU, register file and unified memory, and stalls on a memory-ready handshake.

## Interface
- No parameters.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `opcode` in 6: IR[31:26].
- `funct` in 6: IR[5:0].
- `zero_signal` in 1: ALU equality flag (valid in BRANCH).
- `mem_ready` in 1: memory completes the current access this cycle.
- `ir_write` out 1: load IR from memory data.
- `pc_write` out 1: load PC.
- `pc_src` out 2: 00 ALU result (PC+4), 01 ALUOut (branch target), 10 jump target {PC[31:28],IR[25:0],00}, 11 ALU result (jr).
- `i_or_d` out 1: memory address select, 0 PC, 1 ALUOut.
- `mem_read`, `mem_write` out 1 each: memory strobes.
- `reg_write` out 1: register-file write enable.
- `reg_dst` out 2: 00 rt, 01 rd, 10 $31.
- `mem_to_reg` out 2: 00 ALUOut, 01 MDR, 10 PC.
- `alu_src_a` out 1: 0 PC, 1 register A.
- `alu_src_b` out 2: 00 register B, 01 constant 4, 10 extended immediate, 11 sign-extended immediate shifted left by 2.
- `ext_sel` out 1: 0 sign-extend, 1 zero-extend.
- `alu_control` out 4: ALU operation code.
- `instr_done` out 1: one-cycle pulse in the final cycle of each instruction.
- `illegal` out 1: one-cycle pulse on an unsupported opcode or funct.
- `state` out 4: current state, for debug.

## Operation
- ALU codes, binary: add 0010, addi 0011, lw 1000, sw 1001, sll 0100, and 0000, andi 0001, nor 1100, beq 1010, jal 1011, jr 1111, slt 0111.
- Supported opcodes: R-type 000000, addi 001000, andi 001100, lw 100011, sw 101011, beq 000100, jal 000011.
- Supported R-type funct values: add 100000, and 100100, nor 100111, slt 101010, sll 000000, jr 001000.
- Defaults in every state unless listed below: all enables 0, `alu_control`=add, selects 0.
- FETCH: `mem_read`=1, `i_or_d`=0, `alu_src_a`=0, `alu_src_b`=01, `pc_src`=00.
  - `ir_write` and `pc_write` equal `mem_ready`, combinationally.
  - Stays in FETCH until `mem_ready`, then goes to DECODE.
- DECODE: `alu_src_a`=0, `alu_src_b`=11, add; this precomputes the branch target into ALUOut. Next state by opcode:
  - lw/sw → MEMADR
  - R-type → EXEC_R, or JR when funct=001000
  - addi/andi → EXEC_I
  - beq → BRANCH
  - jal → JAL
  - any other opcode, or R-type with an unlisted funct → ILLEGAL
- MEMADR: `alu_src_a`=1, `alu_src_b`=10, `ext_sel`=0, code lw or sw; → MEMRD or MEMWR.
- MEMRD: `mem_read`=1, `i_or_d`=1; holds until `mem_ready`, then → MEMWB.
- MEMWB: `reg_write`=1, `reg_dst`=00, `mem_to_reg`=01, `instr_done`=1; → FETCH.
- MEMWR: `mem_write`=1, `i_or_d`=1; holds until `mem_ready`. On the `mem_ready` cycle `instr_done`=1; → FETCH.
- EXEC_R: `alu_src_a`=1, `alu_src_b`=00, code from funct; → RWB.
- RWB: `reg_write`=1, `reg_dst`=01, `mem_to_reg`=00, `instr_done`=1; → FETCH.
- EXEC_I: `alu_src_a`=1, `alu_src_b`=10, `ext_sel`=0 for addi and 1 for andi, code addi/andi; → IWB.
- IWB: `reg_write`=1, `reg_dst`=00, `mem_to_reg`=00, `instr_done`=1; → FETCH.
- BRANCH: `alu_src_a`=1, `alu_src_b`=00, code beq, `pc_src`=01, `pc_write`=`zero_signal`, `instr_done`=1; → FETCH.
- JAL: code jal, `pc_write`=1, `pc_src`=10, `reg_write`=1, `reg_dst`=10, `mem_to_reg`=10 (PC already holds PC+4), `instr_done`=1; → FETCH.
- JR: `alu_src_a`=1, code jr, `pc_write`=1, `pc_src`=11, `instr_done`=1; → FETCH.
- ILLEGAL: `illegal`=1, no writes; → FETCH. The instruction is skipped; the PC is already advanced.

## Timing
- Moore outputs decode from the registered state. The only Mealy outputs are FETCH `ir_write`/`pc_write` (on `mem_ready`), MEMWR `instr_done` (on `mem_ready`) and BRANCH `pc_write` (on `zero_signal`).
- Latency with zero memory wait:
  - R-type, addi, andi, sw: 4 cycles.
  - lw: 5 cycles.
  - beq, jal, jr, illegal: 3 cycles.
  - Each cycle with `mem_ready`=0 in FETCH, MEMRD or MEMWR adds one cycle.
- `opcode`/`funct` are sampled only in DECODE and EXEC_R; the IR is stable after FETCH.
- Reset:
  - While `rst`=1, every enable output, `instr_done` and `illegal` is forced to 0.
  - `alu_control`=0010 and `state`=FETCH on the next edge.
  - Reset in mid-instruction, including during a memory wait, abandons the instruction with no write issued.
- `mem_ready` high outside FETCH, MEMRD and MEMWR is ignored.

## Test plan
- add, with `mem_ready` tied 1 → states FETCH, DECODE, EXEC_R, RWB.
  - `alu_control`=0010 in EXEC_R.
  - `reg_write`=1 and `reg_dst`=01 in cycle 4.
  - `instr_done` pulses in cycle 4.
- lw, with `mem_ready` low for 2 cycles in MEMRD → 7 cycles total.
  - `mem_read`=1 and `i_or_d`=1 held through the wait.
  - `reg_write`=1 and `mem_to_reg`=01 in the last cycle.
- beq with `zero_signal`=1 → `pc_write`=1 and `pc_src`=01 in cycle 3. Repeat with `zero_signal`=0 → `pc_write`=0.
- jal, then jr (funct 001000):
  - jal → `reg_dst`=10, `mem_to_reg`=10, `pc_src`=10, 3 cycles.
  - jr → `pc_src`=11, code 1111.
- opcode 111111 → `illegal` pulses in cycle 3, no write enable asserted, back to FETCH.
- `rst` asserted in MEMWR while `mem_ready`=0:
  - `mem_write` drops in the same cycle.
  - The next state is FETCH.
  - `instr_done` never pulses.
